mfm_flux_writer: RTL and testbench
==================================

MFM_FLUX_WRITER -- requirements
Module: mfm_flux_writer

Interface
REQ-001 Parameter clkspd, default 65000000, SHALL be the i_Clk frequency in Hz.
REQ-002 Derived constants SHALL be: T_S=floor(2.0e-6*clkspd), T_M=floor(3.0e-6*clkspd), T_L=floor(4.0e-6*clkspd), T_PW=floor(0.15e-6*clkspd). At the default clkspd these are 130, 195, 260 and 9 cycles.
REQ-003 i_Clk  input  1  SHALL be the sole clock; all logic is clocked on its rising edge.
REQ-004 i_Rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 i_Enable  input  1  SHALL enable writing; low aborts writing and blocks new symbols.
REQ-006 i_Valid  input  1  SHALL indicate that i_Sym holds a symbol.
REQ-007 i_Sym  input  2  SHALL carry the symbol: 00=S (2us), 01=M (3us), 10=L (4us), 11=invalid.
REQ-008 o_Ready  output  1  SHALL indicate the block can accept a symbol.
REQ-009 o_Flux  output  1  SHALL be the active-high write pulse; each rising edge is one flux transition.
REQ-010 o_Busy  output  1  SHALL be high while an interval is running or a pulse is being driven.
REQ-011 o_Underrun  output  1  SHALL be a one-cycle strobe: an interval ended with no next symbol.
REQ-012 o_Error  output  1  SHALL be a one-cycle strobe: an invalid symbol was accepted.

Function
REQ-013 A transfer SHALL occur on each cycle where i_Valid && o_Ready.
REQ-014 o_Ready SHALL equal i_Enable && !hold_valid. It is combinational from i_Enable and a registered 1-entry hold register.
REQ-015 The block SHALL use two states. IDLE: no interval is running. RUN: the interval counter is active.
REQ-016 In IDLE, a valid transfer (S/M/L) SHALL enter RUN on the next cycle with that symbol's interval at count 0. The symbol is not placed in the hold register.
REQ-017 In RUN, a transfer SHALL be stored in the hold register, setting hold_valid.
REQ-018 The interval counter SHALL count 0..T_x-1, where T_x is the active symbol's length. Its width SHALL be clog2(T_L+1) bits.
REQ-019 At count T_x-1, o_Flux SHALL rise on the next cycle and stay high for exactly T_PW cycles, driven by a separate pulse counter. Consecutive o_Flux rising edges are therefore exactly T_x cycles apart.
REQ-020 At count T_x-1 with hold_valid set, the held symbol SHALL become active with count 0 on the next cycle, and hold_valid SHALL clear.
REQ-021 At count T_x-1 with hold_valid clear and a same-cycle valid transfer, the transferred symbol SHALL become the next active interval directly, with no underrun.
REQ-022 At count T_x-1 with no next symbol, the block SHALL assert o_Underrun for one cycle and return to IDLE. The closing o_Flux pulse SHALL still complete.
REQ-023 The first symbol after IDLE SHALL produce its pulse T_x+1 cycles after the transfer cycle. The interval is measured from entry to RUN.
REQ-024 A transfer with i_Sym=11 SHALL complete the handshake, assert o_Error one cycle later for one cycle, and be discarded. Scheduling then proceeds as if no symbol had arrived.
REQ-025 i_Enable low in any cycle SHALL, on the next cycle: force IDLE, clear the counters, clear hold_valid, and drive o_Flux low, truncating any pulse in progress. No o_Underrun SHALL be raised.
REQ-026 o_Busy SHALL be high when state==RUN or the pulse counter is nonzero.
REQ-027 o_Flux, o_Busy, o_Underrun and o_Error SHALL be registered outputs.

Reset
REQ-028 Assertion of i_Rst_n low SHALL immediately set: state IDLE, counters 0, hold_valid 0, o_Flux 0, o_Busy 0, o_Underrun 0, o_Error 0.
REQ-029 Reset SHALL be released synchronously: the first transfer is accepted no earlier than the first rising edge after i_Rst_n goes high.

Verification (clkspd=65000000)
REQ-030 Reset, i_Enable=1, transfer S at cycle 0 -> o_Flux rises at cycle 131, high 9 cycles; o_Underrun pulses at cycle 131; o_Busy low from cycle 140.
REQ-031 Back-to-back S, M, L streamed with i_Valid always high -> o_Flux rising edges 195 cycles apart (M) and 260 cycles apart (L) after the first; o_Underrun pulses only after L.
REQ-032 Transfer M while hold empty, exactly on the cycle the active count reaches T_x-1 -> no o_Underrun; next pulse spacing is 195.
REQ-033 Transfer i_Sym=11 in IDLE -> o_Error high for one cycle; no o_Flux pulse; stays IDLE; o_Ready stays 1.
REQ-034 Deassert i_Enable during the 4th cycle of an o_Flux pulse, with hold full -> o_Flux low next cycle; hold cleared; o_Ready=0 while disabled; no o_Underrun; o_Busy=0.
REQ-035 Assert i_Rst_n low mid-interval -> all outputs 0 asynchronously, before the next clock edge; after release, a new S transfer behaves as in REQ-030.

Source files
------------

// File: rtl/mfm_flux_writer.sv
// rtl/mfm_flux_writer.sv - MFM flux-transition writer driven by S/M/L interval symbols
module mfm_flux_writer #(
    parameter int clkspd = 65000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Enable,
    input  logic       i_Valid,
    input  logic [1:0] i_Sym,
    output logic       o_Ready,
    output logic       o_Flux,
    output logic       o_Busy,
    output logic       o_Underrun,
    output logic       o_Error
);

    // Interval and pulse lengths in i_Clk cycles; integer math gives the floor.
    localparam longint CLK_L = longint'(clkspd);
    localparam int T_S  = int'((CLK_L * 2) / 1000000);
    localparam int T_M  = int'((CLK_L * 3) / 1000000);
    localparam int T_L  = int'((CLK_L * 4) / 1000000);
    localparam int T_PW = int'((CLK_L * 15) / 100000000);

    localparam int CW = $clog2(T_L + 1);
    localparam int PW = $clog2(T_PW + 1);

    localparam logic [CW-1:0] LAST_S = CW'(T_S - 1);
    localparam logic [CW-1:0] LAST_M = CW'(T_M - 1);
    localparam logic [CW-1:0] LAST_L = CW'(T_L - 1);
    localparam logic [PW-1:0] PULSE_LEN = PW'(T_PW);

    localparam logic [1:0] SYM_S   = 2'b00;
    localparam logic [1:0] SYM_M   = 2'b01;
    localparam logic [1:0] SYM_BAD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      cur_sym, cur_sym_n;
    logic            hold_valid, hold_valid_n;
    logic [1:0]      hold_sym, hold_sym_n;
    logic [PW-1:0]   pulse_cnt, pulse_cnt_n;
    logic            flux_n, busy_n, underrun_n, error_n;
    logic            pulse_start;
    logic            xfer, sym_ok, at_end;

    // Final count value of the interval for a given symbol.
    function automatic logic [CW-1:0] last_count(input logic [1:0] sym);
        case (sym)
            SYM_S:   last_count = LAST_S;
            SYM_M:   last_count = LAST_M;
            default: last_count = LAST_L;
        endcase
    endfunction

    assign o_Ready = i_Enable && !hold_valid;
    assign xfer    = i_Valid && o_Ready;
    assign sym_ok  = xfer && (i_Sym != SYM_BAD);
    assign at_end  = (cnt == last_count(cur_sym));

    // Next-state: interval scheduling, hold register and pulse counter.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        cur_sym_n    = cur_sym;
        hold_valid_n = hold_valid;
        hold_sym_n   = hold_sym;
        pulse_start  = 1'b0;
        underrun_n   = 1'b0;
        error_n      = xfer && (i_Sym == SYM_BAD);

        if (!i_Enable) begin
            state_n      = IDLE;
            cnt_n        = '0;
            hold_valid_n = 1'b0;
            error_n      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sym_ok) begin
                        state_n   = RUN;
                        cnt_n     = '0;
                        cur_sym_n = i_Sym;
                    end
                end
                RUN: begin
                    if (at_end) begin
                        pulse_start = 1'b1;
                        cnt_n       = '0;
                        if (hold_valid) begin
                            cur_sym_n    = hold_sym;
                            hold_valid_n = 1'b0;
                        end else if (sym_ok) begin
                            // Symbol arriving exactly at the boundary chains directly.
                            cur_sym_n = i_Sym;
                        end else begin
                            state_n    = IDLE;
                            underrun_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                        if (sym_ok) begin
                            hold_valid_n = 1'b1;
                            hold_sym_n   = i_Sym;
                        end
                    end
                end
            endcase
        end

        if (!i_Enable) begin
            pulse_cnt_n = '0;
        end else if (pulse_start) begin
            pulse_cnt_n = PULSE_LEN;
        end else if (pulse_cnt != '0) begin
            pulse_cnt_n = pulse_cnt - PW'(1);
        end else begin
            pulse_cnt_n = pulse_cnt;
        end

        flux_n = (pulse_cnt_n != '0);
        busy_n = (state_n == RUN) || (pulse_cnt_n != '0);
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_sym    <= SYM_S;
            hold_valid <= 1'b0;
            hold_sym   <= SYM_S;
            pulse_cnt  <= '0;
            o_Flux     <= 1'b0;
            o_Busy     <= 1'b0;
            o_Underrun <= 1'b0;
            o_Error    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cur_sym    <= cur_sym_n;
            hold_valid <= hold_valid_n;
            hold_sym   <= hold_sym_n;
            pulse_cnt  <= pulse_cnt_n;
            o_Flux     <= flux_n;
            o_Busy     <= busy_n;
            o_Underrun <= underrun_n;
            o_Error    <= error_n;
        end
    end

endmodule

// File: tb/tb_mfm_flux_writer.sv
// tb/tb_mfm_flux_writer.sv - self-checking bench for mfm_flux_writer
module tb_mfm_flux_writer;

    logic       i_Clk = 1'b0;
    logic       i_Rst_n;
    logic       i_Enable;
    logic       i_Valid;
    logic [1:0] i_Sym;
    logic       o_Ready;
    logic       o_Flux;
    logic       o_Busy;
    logic       o_Underrun;
    logic       o_Error;

    mfm_flux_writer #(.clkspd(65000000)) dut (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Enable   (i_Enable),
        .i_Valid    (i_Valid),
        .i_Sym      (i_Sym),
        .o_Ready    (o_Ready),
        .o_Flux     (o_Flux),
        .o_Busy     (o_Busy),
        .o_Underrun (o_Underrun),
        .o_Error    (o_Error)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [1:0] sym;
        int         rise;
        int         fall;
        int         und;
        int         n_und;
        int         err;
        int         bfall;
        int         n_rise;
    } vec_t;

    vec_t vecs[4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic pf, pb;
    int rise_q[$], fall_q[$], und_q[$], err_q[$], bfall_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int nth(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    // Advance to the next falling edge and log events seen in that cycle.
    task automatic tick();
        @(negedge i_Clk);
        cyc++;
        if (o_Flux && !pf) rise_q.push_back(cyc);
        if (!o_Flux && pf) fall_q.push_back(cyc);
        if (o_Underrun) und_q.push_back(cyc);
        if (o_Error) err_q.push_back(cyc);
        if (!o_Busy && pb) bfall_q.push_back(cyc);
        pf = o_Flux;
        pb = o_Busy;
    endtask

    task automatic clear_log();
        rise_q.delete();
        fall_q.delete();
        und_q.delete();
        err_q.delete();
        bfall_q.delete();
        cyc = 0;
    endtask

    // Present one symbol for the transfer cycle (cycle 0), then drop i_Valid.
    task automatic send(input string name, input logic [1:0] s);
        clear_log();
        check({name, "_ready"}, int'(o_Ready), 1);
        i_Valid = 1'b1;
        i_Sym   = s;
        tick();
        i_Valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b00, 131, 140, 131, 1, -1, 140, 1};
        vecs[1] = '{2'b01, 196, 205, 196, 1, -1, 205, 1};
        vecs[2] = '{2'b10, 261, 270, 261, 1, -1, 270, 1};
        vecs[3] = '{2'b11,  -1,  -1,  -1, 0,  1,  -1, 0};

        i_Rst_n  = 1'b0;
        i_Enable = 1'b0;
        i_Valid  = 1'b0;
        i_Sym    = 2'b00;
        cyc      = 0;
        pf       = 1'b0;
        pb       = 1'b0;

        repeat (2) @(negedge i_Clk);
        check("rst_flux", int'(o_Flux), 0);
        check("rst_busy", int'(o_Busy), 0);
        check("rst_underrun", int'(o_Underrun), 0);
        check("rst_error", int'(o_Error), 0);
        check("rst_ready_disabled", int'(o_Ready), 0);
        i_Enable = 1'b1;
        #1;
        check("rst_ready_enabled", int'(o_Ready), 1);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;

        // Single symbols from IDLE.
        for (int i = 0; i < 4; i++) begin
            send($sformatf("v%0d", i), vecs[i].sym);
            repeat (300) tick();
            check($sformatf("v%0d_rise", i), nth(rise_q, 0), vecs[i].rise);
            check($sformatf("v%0d_nrise", i), rise_q.size(), vecs[i].n_rise);
            check($sformatf("v%0d_fall", i), nth(fall_q, 0), vecs[i].fall);
            check($sformatf("v%0d_und", i), nth(und_q, 0), vecs[i].und);
            check($sformatf("v%0d_nund", i), und_q.size(), vecs[i].n_und);
            check($sformatf("v%0d_err", i), nth(err_q, 0), vecs[i].err);
            check($sformatf("v%0d_nerr", i), err_q.size(), (vecs[i].err < 0) ? 0 : 1);
            check($sformatf("v%0d_bfall", i), nth(bfall_q, 0), vecs[i].bfall);
            check($sformatf("v%0d_idle_busy", i), int'(o_Busy), 0);
            check($sformatf("v%0d_idle_ready", i), int'(o_Ready), 1);
        end

        // Back-to-back S, M, L with i_Valid held high.
        clear_log();
        i_Valid = 1'b1;
        i_Sym   = 2'b00;
        tick();
        i_Sym = 2'b01;
        tick();
        i_Sym = 2'b10;
        while (!o_Ready && cyc < 400) tick();
        check("b2b_ready_cycle", cyc, 131);
        tick();
        i_Valid = 1'b0;
        while (cyc < 700) tick();
        check("b2b_nrise", rise_q.size(), 3);
        check("b2b_rise0", nth(rise_q, 0), 131);
        check("b2b_gap_m", nth(rise_q, 1) - nth(rise_q, 0), 195);
        check("b2b_gap_l", nth(rise_q, 2) - nth(rise_q, 1), 260);
        check("b2b_nund", und_q.size(), 1);
        check("b2b_und", nth(und_q, 0), 586);

        // Symbol arriving exactly on the last count of the active interval.
        send("edge", 2'b00);
        while (cyc < 130) tick();
        i_Valid = 1'b1;
        i_Sym   = 2'b01;
        tick();
        i_Valid = 1'b0;
        while (cyc < 400) tick();
        check("edge_rise0", nth(rise_q, 0), 131);
        check("edge_gap", nth(rise_q, 1) - nth(rise_q, 0), 195);
        check("edge_und", nth(und_q, 0), 326);
        check("edge_nund", und_q.size(), 1);

        // Disable during the 4th pulse cycle with the hold register full.
        send("abort", 2'b00);
        i_Valid = 1'b1;
        i_Sym   = 2'b10;
        tick();
        i_Valid = 1'b0;
        while (cyc < 131) tick();
        check("abort_ready_131", int'(o_Ready), 1);
        i_Valid = 1'b1;
        i_Sym   = 2'b01;
        tick();
        i_Valid = 1'b0;
        check("abort_hold_full", int'(o_Ready), 0);
        tick();
        tick();
        check("abort_flux_c134", int'(o_Flux), 1);
        i_Enable = 1'b0;
        #1;
        check("abort_ready_dis", int'(o_Ready), 0);
        tick();
        check("abort_flux_off", int'(o_Flux), 0);
        check("abort_busy_off", int'(o_Busy), 0);
        check("abort_ready_off", int'(o_Ready), 0);
        tick();
        i_Enable = 1'b1;
        #1;
        check("abort_hold_clr", int'(o_Ready), 1);
        while (cyc < 700) tick();
        check("abort_nrise", rise_q.size(), 1);
        check("abort_nund", und_q.size(), 0);
        check("abort_idle_busy", int'(o_Busy), 0);

        // Asynchronous reset mid-pulse, then a fresh S.
        send("areset", 2'b00);
        while (cyc < 133) tick();
        check("areset_flux_pre", int'(o_Flux), 1);
        check("areset_busy_pre", int'(o_Busy), 1);
        i_Rst_n = 1'b0;
        #1;
        check("areset_flux", int'(o_Flux), 0);
        check("areset_busy", int'(o_Busy), 0);
        check("areset_underrun", int'(o_Underrun), 0);
        check("areset_error", int'(o_Error), 0);
        tick();
        tick();
        i_Rst_n = 1'b1;
        send("post", 2'b00);
        while (cyc < 300) tick();
        check("post_rise", nth(rise_q, 0), 131);
        check("post_fall", nth(fall_q, 0), 140);
        check("post_und", nth(und_q, 0), 131);
        check("post_bfall", nth(bfall_q, 0), 140);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
